// File: rtl/wx_mem_responder.sv
// Banked 1-bit weight/activation store with host preload, compute-port access and bulk clear.
// Reads are combinational in SERVE; writes, host preload and clear steps land on the next posedge.
// Host writes are flow-controlled by a registered host_ready; compute strobes are never stalled.
module wx_mem_responder #(
  parameter int W_ADDR_LEN = 20,
  parameter int W_SEL_LEN  = 2,
  parameter int X_ADDR_LEN = 10,
  parameter int X_SEL_LEN  = 2,
  parameter int W_DEPTH    = 16,
  parameter int X_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_mode,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_target,
  input  logic [1:0]            host_sel,
  input  logic [W_ADDR_LEN-1:0] host_addr,
  input  logic                  host_data,
  input  logic                  clear_req,
  output logic                  clear_done,
  output logic                  err_oob,
  input  logic                  wx_write,
  input  logic [W_ADDR_LEN-1:0] w_addr,
  input  logic [W_SEL_LEN-1:0]  w_sel,
  input  logic                  w_wq,
  output logic                  w_data,
  input  logic [X_ADDR_LEN-1:0] x_addr,
  input  logic [X_SEL_LEN-1:0]  x_sel,
  input  logic                  x_wq,
  output logic                  x_data
);

  localparam int W_BANKS = 2 ** W_SEL_LEN;
  localparam int X_BANKS = 2 ** X_SEL_LEN;
  localparam int W_IW    = $clog2(W_DEPTH);
  localparam int X_IW    = $clog2(X_DEPTH);
  localparam int MAX_D   = (W_DEPTH > X_DEPTH) ? W_DEPTH : X_DEPTH;
  localparam int CNT_W   = $clog2(MAX_D + 1);

  localparam logic [W_ADDR_LEN-1:0] W_LIM      = W_ADDR_LEN'(W_DEPTH);
  localparam logic [W_ADDR_LEN-1:0] HX_LIM     = W_ADDR_LEN'(X_DEPTH);
  localparam logic [X_ADDR_LEN-1:0] X_LIM      = X_ADDR_LEN'(X_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(MAX_D - 1);
  localparam logic [CNT_W-1:0]      W_CNT_LIM  = CNT_W'(W_DEPTH);
  localparam logic [CNT_W-1:0]      X_CNT_LIM  = CNT_W'(X_DEPTH);

  typedef enum logic [1:0] {IDLE, PRELOAD, SERVE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic             clear_pend;
  logic [CNT_W-1:0] cnt;

  // Each bank is a bit vector indexed by entry address.
  logic [W_DEPTH-1:0] w_mem [W_BANKS];
  logic [X_DEPTH-1:0] x_mem [X_BANKS];

  logic serve;
  logic w_in_rng, x_in_rng, host_in_rng;
  logic host_acc, clear_go, cnt_last, oob_hit;
  logic [W_IW-1:0] w_idx;
  logic [X_IW-1:0] x_idx;

  assign serve       = (state == SERVE);
  assign w_in_rng    = (w_addr < W_LIM);
  assign x_in_rng    = (x_addr < X_LIM);
  assign w_idx       = w_addr[W_IW-1:0];
  assign x_idx       = x_addr[X_IW-1:0];
  // host_ready is only ever high while in PRELOAD, so it doubles as the state qualifier.
  assign host_acc    = host_valid & host_ready & host_mode;
  assign host_in_rng = host_target ? (host_addr < HX_LIM) : (host_addr < W_LIM);
  // A clear request seen in SERVE/PRELOAD is remembered so a one-cycle pulse still reaches CLEAR.
  assign clear_go    = clear_req | clear_pend;
  assign cnt_last    = (cnt == CNT_LAST);
  assign oob_hit     = (serve & ((w_wq & ~w_in_rng) | (x_wq & ~x_in_rng)))
                     | (host_acc & ~host_in_rng);

  // Combinational read port; out-of-range or non-SERVE reads return 0.
  assign w_data = (serve && w_in_rng) ? w_mem[w_sel][w_idx] : 1'b0;
  assign x_data = (serve && x_in_rng) ? x_mem[x_sel][x_idx] : 1'b0;

  // Next-state selection for the ownership/clear FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_go)       state_nxt = CLEAR;
        else if (host_mode) state_nxt = PRELOAD;
        else                state_nxt = SERVE;
      end
      PRELOAD: if (!host_mode || clear_req) state_nxt = IDLE;
      SERVE:   if (host_mode || clear_req)  state_nxt = IDLE;
      CLEAR:   if (cnt_last)                state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the registered control outputs and the sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      host_ready <= 1'b0;
      clear_done <= 1'b0;
      err_oob    <= 1'b0;
      cnt        <= '0;
      clear_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      host_ready <= (state == PRELOAD) && (state_nxt == PRELOAD);
      clear_done <= (state == CLEAR) && cnt_last;
      cnt        <= ((state == CLEAR) && !cnt_last) ? cnt + 1'b1 : '0;
      if ((state == CLEAR) || (state_nxt == CLEAR)) clear_pend <= 1'b0;
      else if (clear_req)                           clear_pend <= 1'b1;
      if (oob_hit) err_oob <= 1'b1;
    end
  end

  // Array updates: compute writes in SERVE, host writes in PRELOAD, one entry per bank per CLEAR cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        SERVE: begin
          if (w_wq && w_in_rng) w_mem[w_sel][w_idx] <= wx_write;
          if (x_wq && x_in_rng) x_mem[x_sel][x_idx] <= wx_write;
        end
        PRELOAD: begin
          if (host_acc && host_in_rng) begin
            if (host_target) x_mem[host_sel][host_addr[X_IW-1:0]] <= host_data;
            else             w_mem[host_sel][host_addr[W_IW-1:0]] <= host_data;
          end
        end
        CLEAR: begin
          for (int b = 0; b < W_BANKS; b++)
            if (cnt < W_CNT_LIM) w_mem[b][cnt[W_IW-1:0]] <= 1'b0;
          for (int b = 0; b < X_BANKS; b++)
            if (cnt < X_CNT_LIM) x_mem[b][cnt[X_IW-1:0]] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wx_mem_responder.sv
// Directed bench for wx_mem_responder: preload, handshake, compute writes, clear, out-of-range, reset mid-clear.
// Outputs are sampled 1 ns after the rising edge or 1 ns after an input change.
// Clear completion waits are bounded; a timeout is reported as a failed comparison.
module tb_wx_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_mode, host_valid, host_target, host_data;
  logic        host_ready;
  logic [1:0]  host_sel;
  logic [19:0] host_addr;
  logic        clear_req, clear_done, err_oob;
  logic        wx_write;
  logic [19:0] w_addr;
  logic [1:0]  w_sel;
  logic        w_wq, w_data;
  logic [9:0]  x_addr;
  logic [1:0]  x_sel;
  logic        x_wq, x_data;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc;

  always #5 clk = ~clk;

  wx_mem_responder dut (
    .clk(clk), .rst(rst),
    .host_mode(host_mode), .host_valid(host_valid), .host_ready(host_ready),
    .host_target(host_target), .host_sel(host_sel), .host_addr(host_addr),
    .host_data(host_data), .clear_req(clear_req), .clear_done(clear_done),
    .err_oob(err_oob), .wx_write(wx_write),
    .w_addr(w_addr), .w_sel(w_sel), .w_wq(w_wq), .w_data(w_data),
    .x_addr(x_addr), .x_sel(x_sel), .x_wq(x_wq), .x_data(x_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One host write in PRELOAD with host_ready already high.
  task automatic host_wr(input logic tgt, input logic [1:0] sel, input logic [19:0] addr, input logic d);
    host_valid = 1'b1; host_target = tgt; host_sel = sel; host_addr = addr; host_data = d;
    tick();
    host_valid = 1'b0;
  endtask

  // One compute-port write in SERVE.
  task automatic w_wr(input logic [1:0] sel, input logic [19:0] addr, input logic d);
    w_sel = sel; w_addr = addr; wx_write = d; w_wq = 1'b1;
    tick();
    w_wq = 1'b0;
  endtask

  task automatic w_rd(input string tag, input logic [1:0] sel, input logic [19:0] addr, input logic exp);
    w_sel = sel; w_addr = addr;
    #1;
    chk(tag, 32'(w_data), 32'(exp));
  endtask

  task automatic x_rd(input string tag, input logic [1:0] sel, input logic [9:0] addr, input logic exp);
    x_sel = sel; x_addr = addr;
    #1;
    chk(tag, 32'(x_data), 32'(exp));
  endtask

  // Ticks until clear_done is seen; ncyc counts ticks including the one already taken by the caller.
  task automatic wait_done(input int start, input bit poke_mid);
    ncyc = start;
    while (!clear_done && ncyc < 40) begin
      if (poke_mid && ncyc == 6) clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      ncyc++;
    end
    if (!clear_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL clear_timeout: clear_done not seen after %0d cycles", ncyc);
    end
  endtask

  initial begin
    rst = 1'b1; host_mode = 0; host_valid = 0; host_target = 0; host_data = 0;
    host_sel = 0; host_addr = 0; clear_req = 0; wx_write = 0;
    w_addr = 0; w_sel = 0; w_wq = 0; x_addr = 0; x_sel = 0; x_wq = 0;
    do_reset();

    // Reset state
    chk("rst_host_ready", 32'(host_ready), 0);
    chk("rst_clear_done", 32'(clear_done), 0);
    chk("rst_err_oob",    32'(err_oob), 0);
    chk("rst_w_data",     32'(w_data), 0);

    // Initial clear from IDLE: 1 cycle to CLEAR + 16 sweep cycles
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_done(1, 1'b0);
    chk("init_clear_cycles", 32'(ncyc), 17);

    // Preload and handshake
    host_mode = 1'b1;
    tick();
    chk("pre_ready_entry", 32'(host_ready), 0);
    tick();
    chk("pre_ready_next", 32'(host_ready), 1);
    host_wr(1'b0, 2'd1, 20'd3, 1'b1);
    host_wr(1'b1, 2'd0, 20'd2, 1'b1);
    host_valid = 1'b1; host_target = 1'b0; host_sel = 2'd2; host_addr = 20'd7; host_data = 1'b1;
    host_mode = 1'b0;
    tick();
    host_valid = 1'b0;
    chk("idle_ready", 32'(host_ready), 0);
    tick();
    chk("serve_ready", 32'(host_ready), 0);
    w_sel = 2'd1; w_addr = 20'd3; x_sel = 2'd0; x_addr = 10'd2;
    #1;
    chk("pre_w_b1a3", 32'(w_data), 1);
    chk("pre_x_b0a2", 32'(x_data), 1);
    w_rd("pre_w_b1a4", 2'd1, 20'd4, 1'b0);
    w_rd("drop_w_b2a7", 2'd2, 20'd7, 1'b0);

    // Compute writes: read-during-write sees old value, then new value
    x_sel = 2'd2; x_addr = 10'd5; wx_write = 1'b1; x_wq = 1'b1;
    #1;
    chk("rdw_old", 32'(x_data), 0);
    tick();
    x_wq = 1'b0;
    chk("rdw_new", 32'(x_data), 1);
    w_sel = 2'd0; w_addr = 20'd1; x_sel = 2'd2; x_addr = 10'd1;
    w_wq = 1'b1; x_wq = 1'b1; wx_write = 1'b1;
    tick();
    w_wq = 1'b0; x_wq = 1'b0;
    chk("dual_w_b0a1", 32'(w_data), 1);
    chk("dual_x_b2a1", 32'(x_data), 1);

    // Clear from SERVE with a one-cycle pulse and a stray request mid-clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_done(1, 1'b1);
    chk("serve_clear_cycles", 32'(ncyc), 18);
    tick();
    chk("clear_done_1cyc", 32'(clear_done), 0);
    w_rd("clr_w_b1a3", 2'd1, 20'd3, 1'b0);
    w_rd("clr_w_b0a1", 2'd0, 20'd1, 1'b0);
    x_rd("clr_x_b0a2", 2'd0, 10'd2, 1'b0);
    x_rd("clr_x_b2a5", 2'd2, 10'd5, 1'b0);
    x_rd("clr_x_b2a1", 2'd2, 10'd1, 1'b0);
    // If the stray request had re-armed a clear, this write would be ignored
    w_wr(2'd3, 20'd15, 1'b1);
    w_rd("no_reclear", 2'd3, 20'd15, 1'b1);

    // Out of range on the compute port
    x_sel = 2'd0; x_addr = 10'd8; wx_write = 1'b1; x_wq = 1'b1;
    #1;
    chk("oob_x_read", 32'(x_data), 0);
    chk("oob_before", 32'(err_oob), 0);
    tick();
    x_wq = 1'b0;
    chk("oob_set", 32'(err_oob), 1);
    x_rd("oob_no_alias", 2'd0, 10'd0, 1'b0);
    tick();
    chk("oob_sticky", 32'(err_oob), 1);
    do_reset();
    chk("oob_rst", 32'(err_oob), 0);

    // Out of range host write
    host_mode = 1'b1;
    tick();
    tick();
    host_wr(1'b0, 2'd0, 20'd16, 1'b1);
    chk("oob_host", 32'(err_oob), 1);
    host_mode = 1'b0;
    tick();
    tick();
    w_rd("oob_host_no_alias", 2'd0, 20'd0, 1'b0);
    do_reset();
    tick();

    // Reset during CLEAR after five sweep cycles
    w_wr(2'd0, 20'd2, 1'b1);
    w_wr(2'd0, 20'd5, 1'b1);
    w_wr(2'd0, 20'd10, 1'b1);
    x_sel = 2'd3; x_addr = 10'd4; wx_write = 1'b1; x_wq = 1'b1;
    tick();
    x_wq = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_done", 32'(clear_done), 0);
    chk("mid_rst_ready", 32'(host_ready), 0);
    tick();
    chk("mid_rst_done2", 32'(clear_done), 0);
    w_rd("mid_w_a2",  2'd0, 20'd2,  1'b0);
    w_rd("mid_w_a5",  2'd0, 20'd5,  1'b1);
    w_rd("mid_w_a10", 2'd0, 20'd10, 1'b1);
    x_rd("mid_x_b3a4", 2'd3, 10'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
